// File: rtl/flappy_pkg.sv
// Shared state encoding, parameter defaults and button indices for the flappy game controller.
package flappy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_GAMEOVER  = 3'd4
  } state_t;

  localparam int COUNT_FRAMES_DEF = 60;
  localparam int DEAD_FRAMES_DEF  = 2;
  localparam int HOLD_FRAMES_DEF  = 120;

  // Width of the frame and dead counters; parameters must stay below 2**CNT_W.
  localparam int CNT_W = 16;

  localparam logic [1:0] COUNT_START = 2'd3;

  localparam int BTN_START = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_FLAP  = 2;
  localparam int NUM_BTNS  = 3;

endpackage

// File: rtl/flappy_game_ctrl_btn_edge.sv
// Rising-edge detector: registers the previous button level every cycle.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_reg <= 1'b0;
    else       prev_reg <= btn;
  end

  assign rise = btn & ~prev_reg;

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game flow controller: idle, 3-2-1 countdown, play/pause, crash confirmation,
// game-over hold and high-score tracking. All outputs are registered.
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int COUNT_FRAMES = COUNT_FRAMES_DEF,
  parameter int DEAD_FRAMES  = DEAD_FRAMES_DEF,
  parameter int HOLD_FRAMES  = HOLD_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        btn_flap,
  input  logic        dead,
  input  logic [31:0] score,
  output logic        enable,
  output logic        pause,
  output logic        clear,
  output logic        flap,
  output logic [2:0]  state,
  output logic [1:0]  countdown,
  output logic [31:0] high_score,
  output logic        new_record
);

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(COUNT_FRAMES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_FRAMES);

  logic [NUM_BTNS-1:0] btn_vec;
  logic [NUM_BTNS-1:0] rise_vec;
  logic                start_e, pause_e, flap_e;

  assign btn_vec = {btn_flap, btn_pause, btn_start};

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_edge u_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_vec[gi]),
        .rise  (rise_vec[gi])
      );
    end
  endgenerate

  assign start_e = rise_vec[BTN_START];
  assign pause_e = rise_vec[BTN_PAUSE];
  assign flap_e  = rise_vec[BTN_FLAP];

  state_t           state_reg;
  logic [CNT_W-1:0] frame_cnt_reg;
  logic [CNT_W-1:0] dead_cnt_reg;
  logic             enable_reg, pause_reg, clear_reg, flap_reg, new_record_reg;
  logic [1:0]       countdown_reg;
  logic [31:0]      high_score_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      frame_cnt_reg  <= '0;
      dead_cnt_reg   <= '0;
      enable_reg     <= 1'b0;
      pause_reg      <= 1'b0;
      clear_reg      <= 1'b0;
      flap_reg       <= 1'b0;
      countdown_reg  <= 2'd0;
      high_score_reg <= 32'd0;
      new_record_reg <= 1'b0;
    end else begin
      clear_reg <= 1'b0;
      flap_reg  <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (start_e) begin
            state_reg      <= ST_COUNTDOWN;
            clear_reg      <= 1'b1;
            new_record_reg <= 1'b0;
            countdown_reg  <= COUNT_START;
            frame_cnt_reg  <= '0;
          end
        end

        ST_COUNTDOWN: begin
          if (frame_tick) begin
            if (frame_cnt_reg >= COUNT_LAST) begin
              frame_cnt_reg <= '0;
              if (countdown_reg == 2'd1) begin
                state_reg     <= ST_PLAY;
                countdown_reg <= 2'd0;
                enable_reg    <= 1'b1;
                dead_cnt_reg  <= '0;
              end else begin
                countdown_reg <= countdown_reg - 2'd1;
              end
            end else begin
              frame_cnt_reg <= frame_cnt_reg + ONE;
            end
          end
        end

        ST_PLAY: begin
          // Crash confirmation takes priority over a simultaneous pause edge.
          if (frame_tick && dead && dead_cnt_reg >= DEAD_LAST) begin
            state_reg     <= ST_GAMEOVER;
            enable_reg    <= 1'b0;
            frame_cnt_reg <= '0;
            dead_cnt_reg  <= '0;
            if (score > high_score_reg) begin
              high_score_reg <= score;
              new_record_reg <= 1'b1;
            end
          end else begin
            if (frame_tick) dead_cnt_reg <= dead ? dead_cnt_reg + ONE : '0;
            if (pause_e) begin
              state_reg     <= ST_PAUSED;
              pause_reg     <= 1'b1;
              frame_cnt_reg <= '0;
            end else begin
              flap_reg <= flap_e;
            end
          end
        end

        ST_PAUSED: begin
          // The dead run survives a pause so a resumed game continues it.
          if (start_e || pause_e) begin
            state_reg     <= ST_PLAY;
            pause_reg     <= 1'b0;
            frame_cnt_reg <= '0;
          end
        end

        ST_GAMEOVER: begin
          if (start_e && frame_cnt_reg >= HOLD_LIM) begin
            state_reg      <= ST_COUNTDOWN;
            clear_reg      <= 1'b1;
            new_record_reg <= 1'b0;
            countdown_reg  <= COUNT_START;
            frame_cnt_reg  <= '0;
          end else if (frame_tick && frame_cnt_reg < HOLD_LIM) begin
            frame_cnt_reg <= frame_cnt_reg + ONE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign state      = state_reg;
  assign enable     = enable_reg;
  assign pause      = pause_reg;
  assign clear      = clear_reg;
  assign flap       = flap_reg;
  assign countdown  = countdown_reg;
  assign high_score = high_score_reg;
  assign new_record = new_record_reg;

endmodule

// File: doc/flappy_game_ctrl.md
FLAPPY_GAME_CTRL -- requirements
Module: flappy_game_ctrl

Interface
REQ-001 Parameter COUNT_FRAMES, default 60: frame ticks per countdown digit.
REQ-002 Parameter DEAD_FRAMES, default 2: consecutive frame ticks with dead=1 needed to confirm a crash.
REQ-003 Parameter HOLD_FRAMES, default 120: frame ticks in GAMEOVER before start is accepted.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 frame_tick  input  1  one-cycle pulse per video frame.
REQ-007 btn_start  input  1  synchronized level; action on rising edge only.
REQ-008 btn_pause  input  1  synchronized level; action on rising edge only.
REQ-009 btn_flap  input  1  synchronized level; action on rising edge only.
REQ-010 dead  input  1  collision flag from the checker.
REQ-011 score  input  32  live score from the checker.
REQ-012 enable  output  1  checker/world enable.
REQ-013 pause  output  1  checker/world pause.
REQ-014 clear  output  1  one-cycle pulse that resets checker score and world.
REQ-015 flap  output  1  one-cycle bird impulse.
REQ-016 state  output  3  current FSM state code.
REQ-017 countdown  output  2  digit shown during COUNTDOWN (3,2,1), else 0.
REQ-018 high_score  output  32  best score since reset.
REQ-019 new_record  output  1  last game set a new high score.

Function
REQ-020 States SHALL be IDLE, COUNTDOWN, PLAY, PAUSED, GAMEOVER; all outputs SHALL be registered.
REQ-021 IDLE: start edge -> COUNTDOWN with clear=1 the same cycle the state changes; pause/flap edges ignored.
REQ-022 COUNTDOWN: countdown starts at 3, decrements after each COUNT_FRAMES frame ticks; tick that ends digit 1 -> PLAY, countdown=0.
REQ-023 PLAY: enable=1, pause=0; pause edge -> PAUSED; flap edge -> flap pulse on the next cycle.
REQ-024 PLAY: on each frame_tick a dead counter increments if dead=1, else clears to 0; reaching DEAD_FRAMES -> GAMEOVER.
REQ-025 PAUSED: enable=1, pause=1; pause or start edge -> PLAY; dead counter and flap frozen; dead ignored.
REQ-026 GAMEOVER: enable=0, pause=0; hold counter counts frame ticks up to HOLD_FRAMES (saturating); start edge accepted only once saturated -> COUNTDOWN with clear pulse.
REQ-027 On the PLAY->GAMEOVER transition, if score > high_score then high_score <= score and new_record <= 1; equal score SHALL NOT update.
REQ-028 new_record SHALL clear on every clear pulse.
REQ-029 In COUNTDOWN, IDLE and GAMEOVER enable=0, pause=0, flap=0.
REQ-030 Simultaneous crash confirmation and pause edge in PLAY: GAMEOVER wins.
REQ-031 Simultaneous start and pause edges in IDLE/GAMEOVER: start wins.
REQ-032 Edge detection registers SHALL update every cycle in every state, so a button held through a transition produces no further action.
REQ-033 Frame counters SHALL reset to 0 on every state entry.

Reset
REQ-034 reset SHALL force IDLE, enable=0, pause=0, clear=0, flap=0, countdown=0, high_score=0, new_record=0, all counters 0, edge registers 0.
REQ-035 reset asserted mid-game SHALL abort immediately with no clear pulse and no high-score update.

Structure
REQ-036 State encoding and parameter defaults SHALL live in shared package flappy_pkg.
REQ-037 One sub-module btn_edge (registered rising-edge detector) SHALL be instantiated for each of the three buttons.

Verification
REQ-038 COUNT_FRAMES=2: start edge in IDLE -> clear for 1 cycle, countdown 3,2,1 over 6 ticks, then PLAY with enable=1.
REQ-039 PLAY, DEAD_FRAMES=2: dead=1 on one tick, 0 on the next -> stays PLAY; dead=1 on two consecutive ticks -> GAMEOVER, enable=0.
REQ-040 score=7, high_score=0 at crash -> high_score=7, new_record=1; next game crash with score=7 -> high_score=7, new_record=0.
REQ-041 Pause edge in PLAY -> PAUSED, pause=1; flap edge while paused -> no flap; pause edge -> PLAY.
REQ-042 HOLD_FRAMES=3: start edge after 2 ticks in GAMEOVER ignored; after 3 ticks -> COUNTDOWN with clear pulse.
REQ-043 reset asserted in PAUSED with score=9 -> IDLE, high_score=0, clear never pulses.
